// File: rtl/pow_5_res_fifo.sv
// pow_5_res_fifo
//   Result capture stage behind the 5-stage pow_5 pipeline. Each final-stage
//   result (arg^5 truncated to w bits) is stored with an 8-bit sequence index
//   in a small show-ahead FIFO and presented on a valid/ready interface. The
//   whole pipeline is stalled through clk_en while the FIFO is full, so a
//   result held at the pipeline output is never lost and is written once.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   pipe_vld   final-stage valid from the pipeline
//   pipe_res   final-stage result from the pipeline (w bits)
//   clk_en     pipeline advance enable (1 = advance)
//   out_vld    head entry valid
//   out_ready  consumer takes the head entry this cycle
//   out_data   head entry result
//   out_idx    head entry sequence index
//   count      current occupancy (0..depth)
//   stall_cnt  saturating count of cycles with clk_en = 0
module pow_5_res_fifo #(
    parameter int w     = 8,
    parameter int depth = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_vld,
    input  logic [w-1:0]            pipe_res,
    output logic                    clk_en,
    output logic                    out_vld,
    input  logic                    out_ready,
    output logic [w-1:0]            out_data,
    output logic [7:0]              out_idx,
    output logic [$clog2(depth):0]  count,
    output logic [15:0]             stall_cnt
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    typedef struct packed {
        logic [7:0]   idx;
        logic [w-1:0] data;
    } entry_t;

    entry_t        mem [depth];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    seq;
    logic          full;
    logic          wr;
    logic          rd;

    // Flow control is decoded from the registered occupancy only, so there
    // is no combinational path from out_ready to clk_en. A read while full
    // frees a slot, and clk_en rises on the following cycle.
    assign full    = (count == FULL_CNT);
    assign clk_en  = ~full;
    assign out_vld = (count != '0);

    // While clk_en = 0 the pipeline holds its output; ignoring pipe_vld in
    // that window is what makes the held result land exactly once.
    assign wr = clk_en & pipe_vld;
    assign rd = out_vld & out_ready;

    // Show-ahead: head is read combinationally from memory. No bypass, so a
    // write into an empty FIFO becomes visible one cycle later.
    assign head     = mem[rd_ptr];
    assign out_data = head.data;
    assign out_idx  = head.idx;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= '{idx: seq, data: pipe_res};
    end

    // Pointers are PW bits wide; depth is a power of two so they wrap
    // naturally modulo depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
                seq    <= seq + 8'd1;
            end
            if (rd) rd_ptr <= rd_ptr + PW'(1);
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!clk_en && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/pow_5_res_fifo.md
Name: pow_5_res_fifo

Overview:
- Downstream consumer of the 5-stage pow_5 pipeline; captures each final-stage result (arg^5, truncated to w bits) into a small show-ahead FIFO.
- Presents results on a valid/ready output interface, each tagged with a sequence index.
- Drives the pipeline's clk_en, stalling the whole pipeline while the FIFO is full so no result is lost.
- Counts stall cycles for performance monitoring.

Parameters:
w, 8, data width of pipeline result and output data
depth, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pipe_vld  input  1  final-stage valid from pipeline (res_vld bit 0)
pipe_res  input  w  final-stage result from pipeline (pow5 field, res[w-1:0])
clk_en  output  1  enable to pipeline; 1 = pipeline may advance
out_vld  output  1  out_data/out_idx hold a valid entry
out_ready  input  1  consumer accepts entry this cycle
out_data  output  w  head-of-FIFO result
out_idx  output  8  sequence number of head entry
count  output  $clog2(depth)+1  current occupancy
stall_cnt  output  16  saturating count of cycles with clk_en = 0

Behaviour:
- Reset: clk clock; rst_n asynchronous, active-low. While rst_n = 0:
  - wr_ptr, rd_ptr, count, seq counter and stall_cnt are 0.
  - out_vld = 0; clk_en = 1.
  - out_data and out_idx are don't-care; memory contents are not reset.
- clk_en = !full, where full = (count == depth).
  - Decoded from registered state only; no combinational path from out_ready.
- Write: wr = clk_en & pipe_vld.
  - On wr, mem[wr_ptr] <= {seq, pipe_res}; wr_ptr increments; seq increments.
- Stall rule: while clk_en = 0 the pipeline holds its outputs. pipe_vld/pipe_res are ignored, so a held result is written exactly once, on the cycle clk_en returns to 1.
- Read: rd = out_vld & out_ready.
  - out_vld = (count != 0).
  - out_data/out_idx = mem[rd_ptr] (show-ahead, combinational from memory).
  - On rd, rd_ptr increments.
- Occupancy: count updates by +1 (wr only), -1 (rd only), or 0 (both or neither).
- Simultaneous events:
  - wr & rd in the same cycle: count unchanged, both pointers advance.
  - Full with rd: no write that cycle (clk_en = 0). clk_en rises the next cycle.
  - Empty with wr: no bypass. The entry appears on out_vld the cycle after the write, so pipeline-output-to-FIFO-output latency is 1 cycle.
- Pointers: $clog2(depth) bits, wrap modulo depth.
- seq: 8-bit, wraps 255 -> 0. The first result after reset carries index 0.
- stall_cnt: increments each cycle clk_en = 0; saturates at 16'hFFFF.
- Consumer contract: out_data/out_idx stay stable while out_vld = 1 and out_ready = 0.
- Reset mid-operation: all entries discarded, out_vld drops asynchronously, clk_en returns to 1.
- Throughput: one result per cycle when the consumer holds out_ready = 1.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream with 3 entries queued -> out_vld = 0, count = 0, clk_en = 1 immediately; after release the next write carries out_idx = 0.
- Basic pass-through: out_ready = 1; pipe_vld pulses with pipe_res = 1, 32, 243 on consecutive cycles -> out_data 1, 32, 243 each one cycle later, out_idx 0, 1, 2, count never exceeds 1.
- Fill and stall: out_ready = 0; write 5 results (10, 20, 30, 40, 50), holding 50 stable on the input with pipe_vld = 1 -> count = 4, clk_en = 0 after the 4th write, stall_cnt increments per cycle, 50 not written.
  - Then one out_ready pulse -> 10 is read, clk_en = 1 the next cycle, 50 written once, count returns to 4.
- Simultaneous read/write at half full: count = 2, pipe_vld = 1 and out_ready = 1 for 6 cycles -> count stays 2, outputs emerge in order with out_idx contiguous.
- Wrap-around: stream 260 results with out_ready toggling 1/0 -> no loss or duplication, in-order data, out_idx goes 255 -> 0, pointers wrap cleanly.
- Integration with the pow_5 pipeline (w = 8): args 2, 3, 4 with out_ready = 0 and depth = 2.
  - Results 32 and 243 are buffered and the pipeline stalls holding 4^5 mod 256 = 0.
  - After draining, outputs are 32, 243, 0 with out_idx 0, 1, 2.
